// File: rtl/popcount_arb_pkg.sv
// Shared constants, width helpers and result record for the popcount round-robin arbiter.
package popcount_arb_pkg;

    localparam int unsigned STAT_W    = 16;
    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 32;

    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    // Buffered result layout at the default configuration; parameterised users re-declare it at their widths.
    typedef struct packed {
        logic [cnt_w(DEF_WIDTH)-1:0] data;
        logic [id_w(DEF_N_REQ)-1:0]  id;
    } res_entry_t;

endpackage

// File: rtl/bit_population_counter.sv
// Single-cycle registered population counter; result and valid appear one clock after data_val_i.
module bit_population_counter
    import popcount_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_val_o
);

    logic [CNT_W-1:0] cnt_p1;
    logic             vld_p1;

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] d);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum = sum + CNT_W'(d[i]);
        end
        return sum;
    endfunction

    // Stage p0 -> p1
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= data_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (data_val_i) begin
            cnt_p1 <= popcnt(data_i);
        end
    end

    assign cnt_o     = cnt_p1;
    assign cnt_val_o = vld_p1;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter with binary index output; the pointer advances past each accepted grant.
module rr_arbiter
    import popcount_arb_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = id_w(N)
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic [N-1:0]    req_i,
    input  logic            en_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] idx_o
);

    logic [ID_W-1:0] ptr_q;

    // Search upward from the pointer, wrapping modulo N; the first asserted request wins.
    always_comb begin
        logic            found;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        j       = '0;
        for (int k = 0; k < int'(N); k++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            j = sum[ID_W-1:0];
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr_q <= '0;
        end else if (en_i && |req_i) begin
            ptr_q <= (idx_o == ID_W'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/popcount_rr_arbiter.sv
// Shares one population counter among N_REQ requesters with round-robin grant and a 2-entry result buffer.
// Optional per-requester grant statistics are enabled with the POPCOUNT_ARB_STATS_EN macro.
module popcount_rr_arbiter
    import popcount_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned ID_W  = id_w(N_REQ),
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_val_i,
    output logic [N_REQ-1:0]            req_rdy_o,
    output logic [CNT_W-1:0]            res_data_o,
    output logic [ID_W-1:0]             res_id_o,
    output logic                        res_val_o,
    input  logic                        res_rdy_i
`ifdef POPCOUNT_ARB_STATS_EN
    ,
    input  logic                        stat_clr_i,
    output logic [N_REQ-1:0][STAT_W-1:0] stat_cnt_o
`endif
);

    typedef struct packed {
        logic [CNT_W-1:0] data;
        logic [ID_W-1:0]  id;
    } entry_t;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept_en;
    logic             xfer_p0;
    logic             inflight_p1;
    logic [ID_W-1:0]  inflight_id_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             cnt_vld_p1;
    entry_t           fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic [1:0]       occ;
    logic             push;
    logic             pop;
    entry_t           head;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .req_i   (req_val_i),
        .en_i    (accept_en),
        .grant_o (grant),
        .idx_o   (gnt_idx)
    );

    assign req_rdy_o = grant & {N_REQ{accept_en}};
    assign xfer_p0   = |req_rdy_o;

    bit_population_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .data_i     (req_data_i[gnt_idx]),
        .data_val_i (xfer_p0),
        .cnt_o      (cnt_p1),
        .cnt_val_o  (cnt_vld_p1)
    );

    // Stage p0 -> p1: tag travels beside the counter operand
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= xfer_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (xfer_p0) begin
            inflight_id_p1 <= gnt_idx;
        end
    end

    // Counting the in-flight result reserves its buffer slot, so the non-stallable counter never overruns.
    assign push      = cnt_vld_p1;
    assign pop       = res_val_o && res_rdy_i;
    assign occ       = fifo_cnt + {1'b0, inflight_p1};
    assign accept_en = (occ - {1'b0, pop}) < 2'd2;

    // Stage p1 -> p2: result buffer
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            wr_ptr   <= wr_ptr ^ push;
            rd_ptr   <= rd_ptr ^ pop;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{data: cnt_p1, id: inflight_id_p1};
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign res_val_o  = (fifo_cnt != 2'd0);
    assign res_data_o = res_val_o ? head.data : '0;
    assign res_id_o   = res_val_o ? head.id   : '0;

`ifdef POPCOUNT_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] stat_cnt_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (srst_i || stat_clr_i) begin
            stat_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req_rdy_o[i]) begin
                    stat_cnt_q[i] <= sat_inc(stat_cnt_q[i]);
                end
            end
        end
    end

    assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: doc/popcount_rr_arbiter.md
Name: popcount_rr_arbiter

Overview:
- Shares one `bit_population_counter` instance between N_REQ independent requesters.
- Arbitration is round-robin, with valid/ready on every request channel.
- Each result is tagged with the requester index.
- A 2-entry result buffer gives full throughput (1 op/cycle) under output backpressure, even though the counter cannot stall.
- Sits between the packet-field extractors and the statistics block.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- WIDTH, 32: data width per request; passed to the counter instance.
- ID_W, $clog2(N_REQ): requester tag width (localparam).
- CNT_W, $clog2(WIDTH)+1: result width (localparam).

Ports:
- clk_i, input, 1: clock.
- srst_i, input, 1: synchronous reset, active-high.
- req_data_i, input, N_REQ x WIDTH: per-requester operand.
- req_val_i, input, N_REQ: per-requester valid.
- req_rdy_o, output, N_REQ: per-requester ready; at most one bit high.
- res_data_o, output, CNT_W: popcount result.
- res_id_o, output, ID_W: index of the requester that issued the result.
- res_val_o, output, 1: result valid.
- res_rdy_i, input, 1: downstream ready.

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Ports named clk_i and srst_i.

Behaviour:
- Reset values:
  - req_rdy_o = 0, res_val_o = 0, res_data_o = 0, res_id_o = 0.
  - Round-robin pointer = 0; buffer empty; in-flight flag = 0.
- Handshake rules:
  - A transfer occurs on channel i when req_val_i[i] && req_rdy_o[i].
  - A requester holds data and valid stable until its transfer.
  - req_rdy_o may depend on req_val_i; req_val_i must not depend on req_rdy_o.
- Grant:
  - Combinational one-hot choice among asserted req_val_i.
  - Search starts at the pointer and wraps upward (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - req_rdy_o = grant & {N_REQ{accept_en}}.
  - No valid requests, or accept_en = 0: req_rdy_o = 0.
- Pointer: after a transfer on channel g, ptr <= (g+1) mod N_REQ; wraps from N_REQ-1 to 0. No transfer: ptr unchanged.
- Counter drive: the counter gets the granted data and data_val_i = transfer. The tag is registered alongside it (in-flight flag + in-flight id).
- Result capture: the counter output is valid 1 cycle after the transfer and is written into the 2-entry FIFO (data, id) in that same cycle.
- Flow control:
  - occ = buffered entries + in-flight flag, range 0..2.
  - pop = res_val_o && res_rdy_i.
  - accept_en = (occ - pop) < 2.
  - This guarantees a buffer slot for every in-flight result; results are never dropped or overwritten.
- Latency: transfer at cycle t -> res_val_o at t+2 (when the buffer was empty).
- Throughput: 1 result/cycle while res_rdy_i = 1.
- Ordering: results leave in acceptance order.
- Output: res_val_o = buffer not empty; res_data_o/res_id_o = head entry, held stable while res_val_o && !res_rdy_i.
- Simultaneous pop and push in one cycle: both take effect; occupancy unchanged.
- Reset mid-operation: in-flight and buffered results are discarded; the pointer returns to 0.

Optional Feature:
- Macro: POPCOUNT_ARB_STATS_EN.
- Defined: adds the following ports.
  - stat_clr_i, input, 1.
  - stat_cnt_o, output, N_REQ x 16.
- Per-requester grant counters:
  - Increment on each transfer of that requester.
  - Saturate at 16'hFFFF.
  - Cleared by srst_i or stat_clr_i.
  - When stat_clr_i and a transfer coincide, the result is 0.
- Undefined: no ports, no counters; core behaviour identical.

Decomposition:
- Package popcount_arb_pkg holds:
  - the localparam functions for ID_W/CNT_W;
  - typedef res_entry_t (struct: data CNT_W, id ID_W);
  - the STAT_W = 16 constant.
- Sub-module rr_arbiter holds the one-hot grant, pointer register and a binary index output; it is reusable elsewhere.
- FIFO, occupancy and counter instance live in the top.

Test Plan:
1. Reset, then one request: req_val_i = 4'b0100, data 32'hF0F0_0001, res_rdy_i = 1 -> res_val_o at t+2, res_data_o = 9, res_id_o = 2; then idle.
2. All requesters valid continuously, res_rdy_i = 1 -> grants 0,1,2,3,0,... one per cycle, one result per cycle, ids in grant order.
3. Requesters 1 and 3 valid, ptr = 2 -> grant 3 first, then 1, then 3; pointer wrap verified.
4. Backpressure: all valid, res_rdy_i = 0 from cycle 2 -> at most 2 transfers total, req_rdy_o = 0 afterwards, head stable. Release res_rdy_i -> no loss, order preserved.
5. Boundary data: 32'h0 -> 0; 32'hFFFF_FFFF -> 32 (6-bit result correct).
6. srst_i asserted with 2 results buffered -> next cycle res_val_o = 0, ptr = 0. With POPCOUNT_ARB_STATS_EN, counters = 0 after srst_i, and a counter saturates at 16'hFFFF after forced long run.
